fir4_avg_out_stage: RTL and testbench

//  Output stage downstream of the 4-tap unsigned FIR adder. Consumes the raw (W+2)-bit
//  tap sum, discards the warm-up sums produced before the tap window is full, and

---
 rtl/fir4_avg_out_stage.sv | 130 +++++++++++++
 tb/tb_fir4_avg_out_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir4_avg_out_stage.sv
// fir4_avg_out_stage: output stage behind the 4-tap unsigned FIR adder.
// The stage discards the warm-up sums and divides each remaining sum by 4,
// either truncating or rounding half up. Results are queued in a small FIFO
// and presented on a valid/ready master port. The stage counts samples it
// drops because the FIFO is full.
module fir4_avg_out_stage #(
  parameter int W      = 16,
  parameter int DEPTH  = 4,
  parameter int WARMUP = 4,
  parameter int RND    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [W+1:0]             sum_in,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [W-1:0]             m_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // Warm-up counter must hold 0..WARMUP. The count is at least 1 bit wide, so
  // WARMUP=0 still builds.
  localparam int CW = $clog2(WARMUP + 2);
  localparam logic [W+2:0] RND_ADD = (RND != 0) ? (W+3)'(2) : '0;
  localparam logic [W+1:0] SUM_MAX = {{W{1'b1}}, 2'b00};

  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  logic [W+2:0]  avg_full;
  logic          in_warm, eligible, pop, push, drop, full;

  // Average the tap sum. The result is shifted down, so only the low W bits
  // can be non-zero for a legal sum.
  always_comb begin
    avg_full = ({1'b0, sum_in} + RND_ADD) >> 2;
  end

  // Handshake, warm-up qualification and the push/pop/drop decisions.
  always_comb begin
    in_warm  = (wcnt_q < CW'(WARMUP));
    eligible = in_valid && !in_warm;
    full     = (level_q == LW'(DEPTH));
    pop      = (level_q != '0) && m_ready;
    push     = eligible && (!full || pop);
    drop     = eligible && full && !pop;
  end

  // Next-state logic for counters, pointers, FIFO storage and overflow status.
  // NOTE: each _d gets its hold value first, so every path assigns it and no latch is inferred.
  always_comb begin
    wcnt_d     = wcnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    mem_d      = mem_q;

    if (in_valid && in_warm) wcnt_d = wcnt_q + CW'(1);

    if (push) begin
      mem_d[wr_ptr_q] = avg_full[W-1:0];
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    // A drop in the same cycle as a clear wins and restarts the count at 1.
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clr)                   drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF)  drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // Control registers with synchronous active-high reset.
  // NOTE: sequential blocks use '<=' only; blocking '=' belongs to the always_comb above.
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wcnt_q     <= wcnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // FIFO storage.
  // NOTE: storage has no reset; level_q == 0 hides stale entries behind m_valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign m_valid  = (level_q != '0);
  assign m_data   = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

  // A legal tap sum always averages into W bits.
  avg_fits_a: assert property (@(posedge clk) disable iff (reset)
    (sum_in <= SUM_MAX) |-> (avg_full[W+2:W] == '0));

endmodule

// File: tb/tb_fir4_avg_out_stage.sv
// Scoreboard bench for fir4_avg_out_stage: the RND=1 and RND=0 instances
// receive the same stimulus and are checked against one cycle model.
module tb_fir4_avg_out_stage;

  localparam int W      = 16;
  localparam int DEPTH  = 4;
  localparam int WARMUP = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, m_ready, ovf_clr;
  logic [W+1:0]  sum_in;
  logic          m_valid1, m_valid0, ovf1, ovf0;
  logic [W-1:0]  m_data1, m_data0;
  logic [LW-1:0] level1, level0;
  logic [7:0]    drop1, drop0;

  fir4_avg_out_stage #(.W(W), .DEPTH(DEPTH), .WARMUP(WARMUP), .RND(1)) u_dut_rnd (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sum_in(sum_in),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .level(level1),
    .ovf(ovf1), .ovf_clr(ovf_clr), .drop_cnt(drop1)
  );

  fir4_avg_out_stage #(.W(W), .DEPTH(DEPTH), .WARMUP(WARMUP), .RND(0)) u_dut_trn (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sum_in(sum_in),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .level(level0),
    .ovf(ovf0), .ovf_clr(ovf_clr), .drop_cnt(drop0)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int exp1[$];
  int exp0[$];

  // Model state. It always mirrors the DUT state after the most recent edge.
  int   m_lev  = 0;
  int   m_wcnt = 0;
  logic m_ovf  = 1'b0;
  int   m_drop = 0;
  bit   mon_en = 1'b0;

  // Drive one cycle. Predict the next state and queue any accepted sample.
  task automatic step(input logic rst, input logic iv, input int s,
                      input logic rdy, input logic clr);
    int   nlev, nw, nd;
    logic no;
    bit   pop, elig, push, drop;
    reset = rst; in_valid = iv; sum_in = s[W+1:0]; m_ready = rdy; ovf_clr = clr;
    if (rst) begin
      nlev = 0; nw = 0; no = 1'b0; nd = 0;
      exp1.delete(); exp0.delete();
    end else begin
      pop  = (m_lev > 0) && rdy;
      elig = iv && (m_wcnt == WARMUP);
      nw   = (iv && m_wcnt < WARMUP) ? m_wcnt + 1 : m_wcnt;
      push = elig && (m_lev < DEPTH || pop);
      drop = elig && (m_lev == DEPTH) && !pop;
      if (push) begin
        exp1.push_back((s + 2) / 4);
        exp0.push_back(s / 4);
      end
      nlev = m_lev + int'(push) - int'(pop);
      if (drop) begin
        no = 1'b1;
        nd = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
      end else if (clr) begin
        no = 1'b0; nd = 0;
      end else begin
        no = m_ovf; nd = m_drop;
      end
    end
    @(posedge clk); #1;
    m_lev = nlev; m_wcnt = nw; m_ovf = no; m_drop = nd;
    if (rst) mon_en = 1'b1;
  endtask

  // Mid-cycle monitor: checks occupancy against the model and pops the
  // scoreboard on every transfer.
  always @(negedge clk) begin
    int e;
    if (mon_en && !reset) begin
      n_tests++;
      if (m_valid1 !== (m_lev != 0)) begin
        n_fail++;
        $display("FAIL m_valid: got %0b, expected %0b", m_valid1, (m_lev != 0));
      end
      n_tests++;
      if (level1 !== m_lev[LW-1:0]) begin
        n_fail++;
        $display("FAIL level: got %0d, expected %0d", level1, m_lev);
      end
      if (m_valid1 && m_ready) begin
        n_tests++;
        if (exp1.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_data: got %0d, expected no output", m_data1);
        end else begin
          e = exp1.pop_front();
          if (m_data1 !== e[W-1:0]) begin
            n_fail++;
            $display("FAIL rnd_data: got %0d, expected %0d", m_data1, e);
          end
        end
        n_out++;
      end
      if (m_valid0 && m_ready) begin
        n_tests++;
        if (exp0.size() == 0) begin
          n_fail++;
          $display("FAIL trn_data: got %0d, expected no output", m_data0);
        end else begin
          e = exp0.pop_front();
          if (m_data0 !== e[W-1:0]) begin
            n_fail++;
            $display("FAIL trn_data: got %0d, expected %0d", m_data0, e);
          end
        end
      end
    end
  end

  task automatic test_reset;
    step(1, 0, 0, 0, 0);
    step(1, 1, 50, 1, 0);
    n_tests++; if (m_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b, expected 0", m_valid1); end
    n_tests++; if (level1 !== '0)     begin n_fail++; $display("FAIL reset_level: got %0d, expected 0", level1); end
    n_tests++; if (ovf1 !== 1'b0)     begin n_fail++; $display("FAIL reset_ovf: got %0b, expected 0", ovf1); end
    n_tests++; if (drop1 !== 8'd0)    begin n_fail++; $display("FAIL reset_drop_cnt: got %0d, expected 0", drop1); end
  endtask

  task automatic test_warmup;
    int sums[6] = '{100, 200, 300, 400, 8, 12};
    int base = n_out;
    foreach (sums[i]) step(0, 1, sums[i], 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    n_tests++; if (n_out - base != 2) begin n_fail++; $display("FAIL warmup_count: got %0d, expected 2", n_out - base); end
    n_tests++; if (drop1 !== 8'd0)    begin n_fail++; $display("FAIL warmup_drop_cnt: got %0d, expected 0", drop1); end
  endtask

  task automatic test_rounding;
    int sums[4] = '{5, 6, 7, 262140};
    int base = n_out;
    foreach (sums[i]) step(0, 1, sums[i], 1, 0);
    repeat (2) step(0, 0, 0, 1, 0);
    n_tests++; if (n_out - base != 4) begin n_fail++; $display("FAIL rounding_count: got %0d, expected 4", n_out - base); end
  endtask

  task automatic test_overflow;
    int base;
    for (int i = 0; i < 6; i++) step(0, 1, 40 + 4 * i, 0, 0);
    n_tests++; if (level1 !== LW'(4)) begin n_fail++; $display("FAIL ovf_level: got %0d, expected 4", level1); end
    n_tests++; if (ovf1 !== 1'b1)     begin n_fail++; $display("FAIL ovf_flag: got %0b, expected 1", ovf1); end
    n_tests++; if (drop1 !== 8'd2)    begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d, expected 2", drop1); end
    n_tests++; if (ovf0 !== 1'b1 || drop0 !== 8'd2) begin n_fail++; $display("FAIL ovf_trn: got %0b/%0d, expected 1/2", ovf0, drop0); end
    base = n_out;
    repeat (5) step(0, 0, 0, 1, 0);
    n_tests++; if (n_out - base != 4) begin n_fail++; $display("FAIL ovf_drain: got %0d, expected 4", n_out - base); end
  endtask

  task automatic test_simultaneous;
    int base;
    step(0, 0, 0, 0, 1);
    n_tests++; if (ovf1 !== 1'b0 || drop1 !== 8'd0) begin n_fail++; $display("FAIL clr_alone: got %0b/%0d, expected 0/0", ovf1, drop1); end
    for (int i = 0; i < 4; i++) step(0, 1, 1000 + 4 * i, 0, 0);
    base = n_out;
    step(0, 1, 2000, 1, 0);
    n_tests++; if (level1 !== LW'(4)) begin n_fail++; $display("FAIL simul_level: got %0d, expected 4", level1); end
    n_tests++; if (ovf1 !== 1'b0 || drop1 !== 8'd0) begin n_fail++; $display("FAIL simul_ovf: got %0b/%0d, expected 0/0", ovf1, drop1); end
    n_tests++; if (n_out - base != 1) begin n_fail++; $display("FAIL simul_pop: got %0d, expected 1", n_out - base); end
    repeat (5) step(0, 0, 0, 1, 0);
    n_tests++; if (n_out - base != 5) begin n_fail++; $display("FAIL simul_drain: got %0d, expected 5", n_out - base); end
  endtask

  task automatic test_clr_with_drop;
    for (int i = 0; i < 6; i++) step(0, 1, 400 + 4 * i, 0, 0);
    step(0, 1, 424, 0, 1);
    n_tests++; if (ovf1 !== 1'b1 || drop1 !== 8'd1) begin n_fail++; $display("FAIL clr_drop: got %0b/%0d, expected 1/1", ovf1, drop1); end
    step(0, 0, 0, 0, 1);
    n_tests++; if (ovf1 !== 1'b0 || drop1 !== 8'd0) begin n_fail++; $display("FAIL clr_after: got %0b/%0d, expected 0/0", ovf1, drop1); end
    repeat (5) step(0, 0, 0, 1, 0);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < DEPTH + 258; i++) step(0, 1, int'($urandom_range(262140, 0)), 0, 0);
    n_tests++; if (drop1 !== 8'd255 || ovf1 !== 1'b1) begin n_fail++; $display("FAIL drop_sat: got %0b/%0d, expected 1/255", ovf1, drop1); end
    step(0, 0, 0, 0, 1);
    n_tests++; if (drop1 !== 8'd0) begin n_fail++; $display("FAIL sat_clr: got %0d, expected 0", drop1); end
    repeat (5) step(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid;
    int base;
    for (int i = 0; i < 3; i++) step(0, 1, 300 + 4 * i, 0, 0);
    n_tests++; if (level1 !== LW'(3)) begin n_fail++; $display("FAIL mid_level_pre: got %0d, expected 3", level1); end
    step(1, 1, 500, 1, 0);
    n_tests++; if (m_valid1 !== 1'b0 || level1 !== '0) begin n_fail++; $display("FAIL mid_reset: got %0b/%0d, expected 0/0", m_valid1, level1); end
    base = n_out;
    for (int i = 0; i < 4; i++) step(0, 1, 600 + 4 * i, 1, 0);
    n_tests++; if (level1 !== '0) begin n_fail++; $display("FAIL mid_warmup_level: got %0d, expected 0", level1); end
    step(0, 1, 616, 1, 0);
    n_tests++; if (level1 !== LW'(1)) begin n_fail++; $display("FAIL mid_first_push: got %0d, expected 1", level1); end
    repeat (2) step(0, 0, 0, 1, 0);
    n_tests++; if (n_out - base != 1) begin n_fail++; $display("FAIL mid_count: got %0d, expected 1", n_out - base); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 60; i++)
      step(0, ($urandom_range(3, 0) != 0), int'($urandom_range(262140, 0)), $urandom_range(1, 0) == 1, 0);
    repeat (DEPTH + 2) step(0, 0, 0, 1, 0);
    n_tests++; if (exp1.size() != 0 || exp0.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d, expected 0", exp1.size()); end
    n_tests++; if (level1 !== '0) begin n_fail++; $display("FAIL b2b_level: got %0d, expected 0", level1); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; sum_in = '0; m_ready = 1'b0; ovf_clr = 1'b0;
    test_reset;
    test_warmup;
    test_rounding;
    test_overflow;
    test_simultaneous;
    test_clr_with_drop;
    test_saturation;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
